// File: rtl/stack_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : stack_ctrl_if
// Brief    : Request/response, stack-pointer and memory bus bundle for stack_ctrl
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stack_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        req_ready;
    logic [31:0] sp_value;
    logic [1:0]  sp_drive;
    logic [31:0] sp_set;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    // Requester / SP register / memory side
    modport master (
        output req_valid, req_op, req_data, sp_value, mem_rdata, mem_ack,
        input  req_ready, sp_drive, sp_set, mem_addr, mem_wdata, mem_we, mem_re,
               resp_valid, resp_data, resp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_op, req_data, sp_value, mem_rdata, mem_ack,
        output req_ready, sp_drive, sp_set, mem_addr, mem_wdata, mem_we, mem_re,
               resp_valid, resp_data, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/stack_ctrl.sv
//------------------------------------------------------------------------------
// Module   : stack_ctrl
// Brief    : Hardware stack controller: PUSH/POP/PEEK/SETSP with bounds checks
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_ctrl #(
    parameter logic [31:0] STACK_BASE  = 32'd0,
    parameter logic [31:0] STACK_DEPTH = 32'd256,
    parameter int          ACK_TIMEOUT = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    stack_ctrl_if.slave bus
);

    localparam logic [31:0] c_FULL     = STACK_BASE + STACK_DEPTH;
    localparam int          c_WAIT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] c_OP_PUSH  = 2'b00;
    localparam logic [1:0] c_OP_POP   = 2'b01;
    localparam logic [1:0] c_OP_PEEK  = 2'b10;
    localparam logic [1:0] c_OP_SETSP = 2'b11;

    localparam logic [1:0] c_SP_HOLD = 2'b00;
    localparam logic [1:0] c_SP_INC  = 2'b01;
    localparam logic [1:0] c_SP_DEC  = 2'b10;
    localparam logic [1:0] c_SP_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MEM_WR = 3'd1,
        S_MEM_RD = 3'd2,
        S_SP_UPD = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [1:0]          r_spcmd;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_sp_set;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_accept;
    logic                w_acc_err;
    logic                w_in_mem;
    logic                w_timeout;

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_in_mem  = (r_state == S_MEM_WR) || (r_state == S_MEM_RD);
    assign w_timeout = w_in_mem && !bus.mem_ack && (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_acc_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        c_OP_PUSH: begin
                            w_acc_err = (bus.sp_value == c_FULL);
                            w_next    = w_acc_err ? S_RESP : S_MEM_WR;
                        end
                        c_OP_POP, c_OP_PEEK: begin
                            w_acc_err = (bus.sp_value == STACK_BASE);
                            w_next    = w_acc_err ? S_RESP : S_MEM_RD;
                        end
                        default: begin
                            w_acc_err = (bus.req_data < STACK_BASE) || (bus.req_data > c_FULL);
                            w_next    = w_acc_err ? S_RESP : S_SP_UPD;
                        end
                    endcase
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ack)     w_next = S_SP_UPD;
                else if (w_timeout)  w_next = S_RESP;
            end
            S_MEM_RD: begin
                if (bus.mem_ack)     w_next = (r_op == c_OP_POP) ? S_SP_UPD : S_RESP;
                else if (w_timeout)  w_next = S_RESP;
            end
            S_SP_UPD: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request context is captured once at acceptance; sp_value is not looked at again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= c_OP_PUSH;
            r_spcmd  <= c_SP_HOLD;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_sp_set <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_wait   <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.req_op;
                r_err   <= w_acc_err;
                r_wdata <= bus.req_data;
                r_addr  <= (bus.req_op == c_OP_PUSH) ? bus.sp_value : (bus.sp_value - 32'd1);
                case (bus.req_op)
                    c_OP_PUSH: r_spcmd <= c_SP_INC;
                    c_OP_POP:  r_spcmd <= c_SP_DEC;
                    c_OP_PEEK: r_spcmd <= c_SP_HOLD;
                    default:   r_spcmd <= c_SP_LOAD;
                endcase
                if (bus.req_op == c_OP_SETSP) begin
                    r_sp_set <= bus.req_data;
                end
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_in_mem && !bus.mem_ack && !w_timeout) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end

            if ((r_state == S_MEM_RD) && bus.mem_ack) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.mem_we     = (r_state == S_MEM_WR);
    assign bus.mem_re     = (r_state == S_MEM_RD);
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.sp_set     = r_sp_set;
    assign bus.sp_drive   = (r_state == S_SP_UPD) ? r_spcmd : c_SP_HOLD;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_err   = (r_state == S_RESP) && r_err;
    assign bus.resp_data  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_stack_ctrl
// Brief    : Directed self-checking bench for stack_ctrl with default parameters
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    stack_ctrl_if bus ();

    stack_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [31:0] sp);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        bus.sp_value  = sp;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.req_ready, bus.mem_we, bus.mem_re, bus.sp_drive, bus.resp_valid, bus.resp_err} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {bus.req_ready, bus.mem_we, bus.mem_re, bus.sp_drive, bus.resp_valid, bus.resp_err});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.sp_set, bus.resp_data} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.sp_set, bus.resp_data});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_push();
        issue(2'b00, 32'hDEADBEEF, 32'd0);
        bus.sp_value = 32'd77;
        total++;
        if ({bus.mem_we, bus.mem_re, bus.req_ready} !== 3'b100 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL push_wr: got we/re/rdy=%b addr=%h wdata=%h want 100 0 deadbeef",
                     {bus.mem_we, bus.mem_re, bus.req_ready}, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++;
        if (bus.sp_drive !== 2'b01 || bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL push_spupd: got drive=%b we=%b rv=%b want 01 0 0", bus.sp_drive, bus.mem_we, bus.resp_valid);
        end
        tick();
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.sp_drive} !== 4'b1000) begin
            bad++;
            $display("FAIL push_resp: got %b want 1000", {bus.resp_valid, bus.resp_err, bus.sp_drive});
        end
        tick();
        total++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL push_idle: got %b want 01", {bus.resp_valid, bus.req_ready});
        end
    endtask

    task automatic test_pop();
        issue(2'b01, 32'h0, 32'd5);
        total++;
        if ({bus.mem_re, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'd4) begin
            bad++;
            $display("FAIL pop_rd: got re/we=%b addr=%h want 10 4", {bus.mem_re, bus.mem_we}, bus.mem_addr);
        end
        bus.mem_rdata = 32'h1234;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        total++;
        if (bus.sp_drive !== 2'b10 || bus.resp_data !== 32'h1234) begin
            bad++;
            $display("FAIL pop_spupd: got drive=%b data=%h want 10 1234", bus.sp_drive, bus.resp_data);
        end
        tick();
        total++;
        if ({bus.resp_valid, bus.resp_err} !== 2'b10 || bus.resp_data !== 32'h1234) begin
            bad++;
            $display("FAIL pop_resp: got v/e=%b data=%h want 10 1234", {bus.resp_valid, bus.resp_err}, bus.resp_data);
        end
        tick();
    endtask

    task automatic test_peek();
        issue(2'b10, 32'h0, 32'd3);
        total++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'd2) begin
            bad++;
            $display("FAIL peek_rd: got re=%b addr=%h want 1 2", bus.mem_re, bus.mem_addr);
        end
        bus.mem_rdata = 32'hCAFE0001;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.sp_drive} !== 4'b1000 || bus.resp_data !== 32'hCAFE0001) begin
            bad++;
            $display("FAIL peek_resp: got v/e/drv=%b data=%h want 1000 cafe0001",
                     {bus.resp_valid, bus.resp_err, bus.sp_drive}, bus.resp_data);
        end
        tick();
    endtask

    task automatic test_bounds();
        issue(2'b00, 32'h5555, 32'd256);
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_we, bus.sp_drive} !== 5'b11000 || bus.resp_data !== 32'hCAFE0001) begin
            bad++;
            $display("FAIL overflow: got v/e/we/drv=%b data=%h want 11000 cafe0001",
                     {bus.resp_valid, bus.resp_err, bus.mem_we, bus.sp_drive}, bus.resp_data);
        end
        tick();
        issue(2'b01, 32'h0, 32'd0);
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_re, bus.sp_drive} !== 5'b11000) begin
            bad++;
            $display("FAIL underflow: got %b want 11000", {bus.resp_valid, bus.resp_err, bus.mem_re, bus.sp_drive});
        end
        tick();
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL err_one_cycle: got %b want 001", {bus.resp_valid, bus.resp_err, bus.req_ready});
        end
    endtask

    task automatic test_setsp();
        issue(2'b11, 32'h80, 32'd9);
        total++;
        if (bus.sp_drive !== 2'b11 || bus.sp_set !== 32'h80 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL setsp_load: got drive=%b set=%h rv=%b want 11 80 0", bus.sp_drive, bus.sp_set, bus.resp_valid);
        end
        tick();
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.sp_drive} !== 4'b1000) begin
            bad++;
            $display("FAIL setsp_resp: got %b want 1000", {bus.resp_valid, bus.resp_err, bus.sp_drive});
        end
        tick();
        issue(2'b11, 32'h101, 32'd9);
        total++;
        if ({bus.resp_valid, bus.resp_err, bus.sp_drive} !== 4'b1100) begin
            bad++;
            $display("FAIL setsp_range: got %b want 1100", {bus.resp_valid, bus.resp_err, bus.sp_drive});
        end
        tick();
        issue(2'b11, 32'h100, 32'd9);
        total++;
        if (bus.sp_drive !== 2'b11 || bus.sp_set !== 32'h100) begin
            bad++;
            $display("FAIL setsp_full_edge: got drive=%b set=%h want 11 100", bus.sp_drive, bus.sp_set);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int we_cycles;
        int rv_seen;
        int sp_cmds;
        int both;
        we_cycles = 0;
        rv_seen   = 0;
        sp_cmds   = 0;
        both      = 0;
        issue(2'b00, 32'hABCD, 32'd10);
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_we === 1'b1) we_cycles++;
            if (bus.mem_we === 1'b1 && bus.mem_re === 1'b1) both++;
            if (bus.sp_drive !== 2'b00) sp_cmds++;
            if (bus.resp_valid === 1'b1) begin
                rv_seen = 1;
                total++;
                if (bus.resp_err !== 1'b1 || bus.mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_resp: got err=%b we=%b want 1 0", bus.resp_err, bus.mem_we);
                end
                break;
            end
            tick();
        end
        total++;
        if (rv_seen !== 1) begin
            bad++;
            $display("FAIL timeout_bound: got no response want response within 40 cycles");
        end
        total++;
        if (we_cycles !== 16 || sp_cmds !== 0 || both !== 0) begin
            bad++;
            $display("FAIL timeout_strobe: got we_cycles=%0d sp_cmds=%0d both=%0d want 16 0 0", we_cycles, sp_cmds, both);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        issue(2'b01, 32'h0, 32'd7);
        total++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'd6) begin
            bad++;
            $display("FAIL mid_rd: got re=%b addr=%h want 1 6", bus.mem_re, bus.mem_addr);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if ({bus.req_ready, bus.mem_we, bus.mem_re, bus.sp_drive, bus.resp_valid, bus.resp_err} !== 7'b1000000 ||
            {bus.mem_addr, bus.mem_wdata, bus.sp_set, bus.resp_data} !== 128'd0) begin
            bad++;
            $display("FAIL mid_reset: got ctrl=%b data=%h want 1000000 0",
                     {bus.req_ready, bus.mem_we, bus.mem_re, bus.sp_drive, bus.resp_valid, bus.resp_err},
                     {bus.mem_addr, bus.mem_wdata, bus.sp_set, bus.resp_data});
        end
        bus.mem_rdata = 32'h9999;
        bus.mem_ack   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.resp_valid !== 1'b0 || bus.sp_drive !== 2'b00 || bus.req_ready !== 1'b1) stray++;
        end
        bus.mem_ack = 1'b0;
        total++;
        if (stray !== 0 || bus.resp_data !== 32'd0) begin
            bad++;
            $display("FAIL mid_abandon: got stray=%0d data=%h want 0 0", stray, bus.resp_data);
        end
    endtask

    task automatic test_back_to_back();
        bus.mem_ack   = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_data  = 32'h1111;
        bus.sp_value  = 32'd1;
        tick();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd1 || bus.mem_wdata !== 32'h1111) begin
            bad++;
            $display("FAIL b2b_first: got we=%b addr=%h wdata=%h want 1 1 1111", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.req_data = 32'h2222;
        bus.sp_value = 32'd2;
        tick();
        tick();
        total++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_hold: got v/rdy=%b want 10", {bus.resp_valid, bus.req_ready});
        end
        tick();
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %b want 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd2 || bus.mem_wdata !== 32'h2222) begin
            bad++;
            $display("FAIL b2b_second: got we=%b addr=%h wdata=%h want 1 2 2222", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.mem_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = 32'd0;
        bus.sp_value  = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_push();
        test_pop();
        test_peek();
        test_bounds();
        test_setsp();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter STACK_BASE, default 32'd0, meaning the lowest stack word address (empty-stack SP value).
REQ-002 SHALL have parameter STACK_DEPTH, default 32'd256, meaning the stack capacity in words; full SP = STACK_BASE+STACK_DEPTH.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum wait cycles for mem_ack before abort.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset (rst=0 resets at a clk edge).
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 SETSP.
REQ-008 SHALL have port req_data  input  32  push data or new SP value.
REQ-009 SHALL have port req_ready  output  1  controller idle; request accepted when req_valid&req_ready.
REQ-010 SHALL have port sp_value  input  32  current SP from the stack-pointer register.
REQ-011 SHALL have port sp_drive  output  2  SP command: 00 hold, 01 increment, 10 decrement, 11 load sp_set.
REQ-012 SHALL have port sp_set  output  32  SP load value.
REQ-013 SHALL have port mem_addr, mem_wdata  output  32 each  stack memory address / write data.
REQ-014 SHALL have port mem_we, mem_re  output  1 each  write / read strobe, held until mem_ack or timeout.
REQ-015 SHALL have port mem_rdata  input  32  and mem_ack  input  1  read data / transfer complete.
REQ-016 SHALL have port resp_valid  output  1, resp_data  output  32, resp_err  output  1  completion pulse, popped/peeked data, error flag.

Function
REQ-017 SHALL implement states IDLE, MEM_WR, MEM_RD, SP_UPD, RESP; req_ready=1 only in IDLE.
REQ-018 On acceptance SHALL latch op, req_data and sp_value (SPL); later sp_value changes are ignored until IDLE.
REQ-019 PUSH: if SPL == STACK_BASE+STACK_DEPTH -> RESP with resp_err=1 (overflow), no write, no SP change; else -> MEM_WR.
REQ-020 POP/PEEK: if SPL == STACK_BASE -> RESP with resp_err=1 (underflow); else -> MEM_RD.
REQ-021 SETSP: if req_data < STACK_BASE or > STACK_BASE+STACK_DEPTH -> RESP with resp_err=1; else -> SP_UPD with sp_set=req_data.
REQ-022 MEM_WR: mem_we=1, mem_addr=SPL, mem_wdata=latched data; on mem_ack -> SP_UPD with increment.
REQ-023 MEM_RD: mem_re=1, mem_addr=SPL-1 (32-bit wrap arithmetic); on mem_ack capture mem_rdata into resp_data; POP -> SP_UPD with decrement, PEEK -> RESP.
REQ-024 Wait counter SHALL count cycles in MEM_WR/MEM_RD; if ACK_TIMEOUT cycles elapse without mem_ack -> RESP with resp_err=1, no SP change, strobes dropped.
REQ-025 SP_UPD SHALL last exactly one cycle driving the selected sp_drive code; sp_drive=00 in all other states.
REQ-026 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_err=0 on success.
REQ-027 resp_data SHALL hold its last value between responses; PUSH/SETSP responses leave it unchanged.
REQ-028 Latency with zero-wait memory: PUSH/POP resp_valid 3 cycles after acceptance, PEEK 2, SETSP 2, any error 1.
REQ-029 mem_we and mem_re SHALL never be asserted together; mem_ack outside MEM_WR/MEM_RD SHALL be ignored.

Reset
REQ-030 While rst=0 at a clk edge: state IDLE, wait counter 0, sp_drive=00, sp_set=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, resp_valid=0, resp_data=0, resp_err=0.
REQ-031 Reset mid-operation SHALL abandon the request with no response and no further SP command.

Verification
REQ-032 sp_value=0, PUSH data 0xDEADBEEF, ack next cycle -> mem_we at addr 0, sp_drive=01 one cycle, resp_valid 3 cycles after accept, err=0.
REQ-033 sp_value=5, POP, mem_rdata=0x1234 ack immediate -> mem_re addr 4, sp_drive=10, resp_data=0x1234, err=0.
REQ-034 sp_value=256 (defaults), PUSH -> no mem_we, sp_drive=00, resp_valid+resp_err 1 cycle after accept; sp_value=0, POP -> same underflow.
REQ-035 SETSP 0x80 -> sp_drive=11, sp_set=0x80; SETSP 0x101 -> resp_err=1, sp_drive stays 00.
REQ-036 PUSH with mem_ack never asserted -> mem_we held 16 cycles then dropped, resp_err=1, no SP command.
REQ-037 rst=0 during MEM_RD -> next cycle all outputs 0, req_ready=1, no resp_valid.
